// File: rtl/cond_pkg.sv
// Shared condition-code encodings and NZCV flag bit positions.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cond_pkg;

   // Flag bit positions inside Flags[3:0]
   localparam int N = 3;
   localparam int Z = 2;
   localparam int C = 1;
   localparam int V = 0;

   // ARM condition field encodings
   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Condition-field decode against the NZCV flags.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_cond_ex
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;

   assign w_n = i_flags[N];
   assign w_z = i_flags[Z];
   assign w_c = i_flags[C];
   assign w_v = i_flags[V];

   // Evaluate the selected condition; the reserved encoding never passes
   always_comb begin
      o_cond_ex = 1'b0;
      case (cond_e'(i_cond))
         COND_EQ: o_cond_ex = w_z;
         COND_NE: o_cond_ex = ~w_z;
         COND_CS: o_cond_ex = w_c;
         COND_CC: o_cond_ex = ~w_c;
         COND_MI: o_cond_ex = w_n;
         COND_PL: o_cond_ex = ~w_n;
         COND_VS: o_cond_ex = w_v;
         COND_VC: o_cond_ex = ~w_v;
         COND_HI: o_cond_ex = w_c & ~w_z;
         COND_LS: o_cond_ex = ~w_c | w_z;
         COND_GE: o_cond_ex = (w_n == w_v);
         COND_LT: o_cond_ex = (w_n != w_v);
         COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
         COND_LE: o_cond_ex = w_z | (w_n != w_v);
         COND_AL: o_cond_ex = 1'b1;
         default: o_cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: gates PC/reg/mem writes, owns the flag register and an optional flag save stack (COND_UNIT_SHADOW_STACK_EN).
// Latency: write gates combinational; flag/stack updates visible one cycle after the clock edge.
// Backpressure: stall or flush freezes all state and suppresses every write enable.
module cond_unit
   import cond_pkg::*;
#(
   parameter int NF     = 4,
   parameter int NGRP   = 2,
   parameter int SDEPTH = 2
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          valid_i,
   input  logic                          stall,
   input  logic                          flush,
   input  logic [3:0]                    Cond,
   input  logic [NF-1:0]                 ALUFlags,
   input  logic [NGRP-1:0]               FlagW,
   input  logic                          PCS,
   input  logic                          RegW,
   input  logic                          MemW,
   input  logic                          push,
   input  logic                          pop,
   output logic                          PCSrc,
   output logic                          RegWrite,
   output logic                          MemWrite,
   output logic                          CondEx,
   output logic [NF-1:0]                 Flags,
   output logic [$clog2(SDEPTH+1)-1:0]   sdepth,
   output logic                          sfull,
   output logic                          sempty,
   output logic                          serr
);

   localparam int GW = NF / NGRP;
   localparam int DW = $clog2(SDEPTH + 1);

   logic [NF-1:0] r_flags;
   logic          w_act;
   logic          w_go;
   logic          w_pop_ok;
   logic [NF-1:0] w_top;

   cond_eval u_cond_eval (
      .i_cond    (Cond),
      .i_flags   (r_flags[3:0]),
      .o_cond_ex (CondEx)
   );

   // An instruction may act only when valid and neither stalled nor flushed
   assign w_act    = valid_i & ~stall & ~flush;
   assign w_go     = w_act & CondEx;
   assign PCSrc    = PCS  & w_go;
   assign RegWrite = RegW & w_go;
   assign MemWrite = MemW & w_go;
   assign Flags    = r_flags;

   assign sempty = (sdepth == '0);
   assign sfull  = (sdepth == DW'(SDEPTH));

`ifdef COND_UNIT_SHADOW_STACK_EN
   logic [NF-1:0] r_stack [SDEPTH];
   logic [DW-1:0] r_sdepth;
   logic          r_serr;
   logic          w_push_only;
   logic          w_pop_only;
   logic          w_push_ok;
   logic          w_serr_set;

   // Simultaneous push and pop cancel each other out entirely
   assign w_push_only = w_act & push & ~pop;
   assign w_pop_only  = w_act & pop & ~push;
   assign w_push_ok   = w_push_only & ~sfull;
   assign w_pop_ok    = w_pop_only & ~sempty;
   assign w_serr_set  = (w_push_only & sfull) | (w_pop_only & sempty);

   assign sdepth = r_sdepth;
   assign serr   = r_serr;

   // Select the most recently pushed entry (slot sdepth-1)
   always_comb begin
      w_top = '0;
      for (int i = 0; i < SDEPTH; i++) begin
         if (i + 1 == int'(r_sdepth)) w_top = r_stack[i];
      end
   end

   // Stack storage, occupancy and sticky overflow/underflow flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sdepth <= '0;
         r_serr   <= 1'b0;
         for (int i = 0; i < SDEPTH; i++) r_stack[i] <= '0;
      end else begin
         if (w_push_ok) begin
            for (int i = 0; i < SDEPTH; i++) begin
               if (i == int'(r_sdepth)) r_stack[i] <= r_flags;
            end
            r_sdepth <= r_sdepth + DW'(1);
         end else if (w_pop_ok) begin
            r_sdepth <= r_sdepth - DW'(1);
         end
         if (w_serr_set) r_serr <= 1'b1;
      end
   end
`else
   logic w_unused;

   // Without the stack, push/pop have no effect
   assign w_unused = &{1'b0, push, pop};
   assign w_pop_ok = 1'b0;
   assign w_top    = '0;
   assign sdepth   = '0;
   assign serr     = 1'b0;
`endif

   // Flag register: a stack restore overrides the per-group ALU writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flags <= '0;
      end else if (w_pop_ok) begin
         r_flags <= w_top;
      end else begin
         for (int g = 0; g < NGRP; g++) begin
            if (FlagW[g] & w_go) r_flags[g*GW +: GW] <= ALUFlags[g*GW +: GW];
         end
      end
   end

endmodule

// File: tb/tb_cond_unit.sv
`timescale 1ns/1ps
module tb_cond_unit;

   localparam int NF     = 4;
   localparam int NGRP   = 2;
   localparam int SDEPTH = 2;
   localparam int GW     = NF / NGRP;
   localparam int DW     = $clog2(SDEPTH + 1);
`ifdef COND_UNIT_SHADOW_STACK_EN
   localparam bit STK_EN = 1'b1;
`else
   localparam bit STK_EN = 1'b0;
`endif

   logic            clk;
   logic            reset;
   logic            valid_i, stall, flush;
   logic [3:0]      Cond;
   logic [NF-1:0]   ALUFlags;
   logic [NGRP-1:0] FlagW;
   logic            PCS, RegW, MemW, push, pop;
   logic            PCSrc, RegWrite, MemWrite, CondEx;
   logic [NF-1:0]   Flags;
   logic [DW-1:0]   sdepth;
   logic            sfull, sempty, serr;

   cond_unit #(.NF(NF), .NGRP(NGRP), .SDEPTH(SDEPTH)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .stall(stall), .flush(flush),
      .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .push(push), .pop(pop),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .Flags(Flags), .sdepth(sdepth), .sfull(sfull), .sempty(sempty), .serr(serr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   logic [NF-1:0] m_flags;
   logic [NF-1:0] m_stk[$];
   bit            m_serr;

   // Even codes test a predicate, the next odd code is its negation
   function automatic bit cond_pass(input logic [3:0] cc, input logic [NF-1:0] f);
      bit n, z, c, v;
      bit base[7];
      logic [2:0] k;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      if (cc == 4'hE) return 1'b1;
      if (cc == 4'hF) return 1'b0;
      base = '{z, c, n, v, c && !z, n == v, !z && (n == v)};
      k = cc[3:1];
      return cc[0] ? !base[k] : base[k];
   endfunction

   task automatic model_reset();
      m_flags = '0;
      m_stk.delete();
      m_serr = 1'b0;
   endtask

   task automatic check_outs();
      bit act, ce, go;
      int d;
      act = valid_i && !stall && !flush;
      ce  = cond_pass(Cond, m_flags);
      go  = act && ce;
      d   = m_stk.size();
      chk("CondEx",   32'(CondEx),   32'(ce));
      chk("PCSrc",    32'(PCSrc),    32'(PCS && go));
      chk("RegWrite", 32'(RegWrite), 32'(RegW && go));
      chk("MemWrite", 32'(MemWrite), 32'(MemW && go));
      chk("Flags",    32'(Flags),    32'(m_flags));
      chk("sdepth",   32'(sdepth),   32'(d));
      chk("sfull",    32'(sfull),    32'(d == SDEPTH));
      chk("sempty",   32'(sempty),   32'(d == 0));
      chk("serr",     32'(serr),     32'(m_serr));
   endtask

   task automatic model_clk();
      bit act, go;
      logic [NF-1:0] nxt;
      act = valid_i && !stall && !flush;
      go  = act && cond_pass(Cond, m_flags);
      nxt = m_flags;
      for (int g = 0; g < NGRP; g++)
         if (FlagW[g] && go) nxt[g*GW +: GW] = ALUFlags[g*GW +: GW];
      if (STK_EN && act) begin
         if (push && !pop) begin
            if (m_stk.size() == SDEPTH) m_serr = 1'b1;
            else m_stk.push_back(m_flags);
         end else if (pop && !push) begin
            if (m_stk.size() == 0) m_serr = 1'b1;
            else nxt = m_stk.pop_back();
         end
      end
      m_flags = nxt;
   endtask

   task automatic set_in(input bit v, input bit st, input bit fl, input logic [3:0] cc,
                         input logic [NF-1:0] alu, input logic [NGRP-1:0] fw,
                         input bit pcs_i, input bit regw_i, input bit memw_i,
                         input bit pu, input bit po);
      valid_i = v; stall = st; flush = fl; Cond = cc; ALUFlags = alu; FlagW = fw;
      PCS = pcs_i; RegW = regw_i; MemW = memw_i; push = pu; pop = po;
   endtask

   task automatic cyc();
      @(negedge clk);
      check_outs();
      @(posedge clk);
      model_clk();
      #1;
   endtask

   initial begin
      reset = 1'b0;
      set_in(0, 0, 0, 4'h1, '0, '0, 0, 0, 0, 0, 0);
      model_reset();
      #2;
      chk("rst_ne_condex", 32'(CondEx), 32'd1);
      Cond = 4'h0;
      #1;
      chk("rst_eq_condex", 32'(CondEx), 32'd0);
      chk("rst_flags",     32'(Flags),  32'd0);
      chk("rst_sempty",    32'(sempty), 32'd1);
      chk("rst_sfull",     32'(sfull),  32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Unconditional flag write, then EQ passes on Z
      set_in(1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
      cyc();
      set_in(1, 0, 0, 4'h0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
      #1;
      chk("wr_flags", 32'(Flags),  32'b0100);
      chk("eq_pass",  32'(CondEx), 32'd1);
      cyc();

      // Failed NE blocks both register write and flag write
      set_in(1, 0, 0, 4'h1, 4'b1000, 2'b11, 0, 1, 0, 0, 0);
      #1;
      chk("ne_regwrite", 32'(RegWrite), 32'd0);
      cyc();
      chk("ne_flags_hold", 32'(Flags), 32'b0100);

      // Save, overwrite, restore (restore beats a same-cycle write)
      set_in(1, 0, 0, 4'hE, 4'b0110, 2'b11, 0, 0, 0, 0, 0); cyc();
      set_in(1, 0, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 1, 0); cyc();
      set_in(1, 0, 0, 4'hE, 4'b0001, 2'b11, 0, 0, 0, 0, 0); cyc();
      chk("save_wr_flags", 32'(Flags),  32'b0001);
      chk("save_sdepth",   32'(sdepth), STK_EN ? 32'd1 : 32'd0);
      set_in(1, 0, 0, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0, 1); cyc();
      chk("restore_flags",  32'(Flags),  STK_EN ? 32'b0110 : 32'b1111);
      chk("restore_sdepth", 32'(sdepth), 32'd0);

      // Overflow then underflow; serr is sticky
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 0, 4'($urandom_range(0, 15)), 4'($urandom), 2'($urandom), 0, 0, 0, 1, 0);
         cyc();
      end
      chk("ovf_sfull", 32'(sfull),  32'(STK_EN));
      chk("ovf_serr",  32'(serr),   32'(STK_EN));
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 0, 4'hF, 4'($urandom), 2'($urandom), 0, 0, 0, 0, 1);
         cyc();
      end
      chk("unf_sempty", 32'(sempty), 32'd1);
      chk("unf_serr",   32'(serr),   32'(STK_EN));

      // Stall and flush freeze everything
      set_in(1, 1, 0, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 1, 0);
      #1;
      chk("stall_pcsrc", 32'(PCSrc), 32'd0);
      cyc();
      set_in(1, 0, 1, 4'hE, 4'b0101, 2'b11, 1, 1, 1, 1, 0); cyc();
      set_in(1, 0, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 1, 1); cyc();
      set_in(1, 0, 0, 4'hE, 4'b1001, 2'b01, 1, 0, 1, 1, 0); cyc();

      // Reset in the middle of a write+push discards both
      set_in(1, 0, 0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 1, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_reset();
      chk("arst_flags",  32'(Flags),  32'd0);
      chk("arst_sdepth", 32'(sdepth), 32'd0);
      chk("arst_serr",   32'(serr),   32'd0);
      @(posedge clk);
      #1;
      chk("arst_hold_flags", 32'(Flags), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_outs();
      @(posedge clk);
      model_clk();
      #1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         set_in($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                4'($urandom), NF'($urandom), NGRP'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
